// File: rtl/eth_attach_pkg.sv
// Shared definitions for the OPB 10GbE attachment.
// Holds the memory-window geometry, register indices, STATUS bit positions,
// the bus FSM state type and a byte-enable merge helper.
package eth_attach_pkg;

    // Region r lives at offset REGION_STRIDE*(r+1) and spans REGION_SIZE bytes
    localparam logic [31:0] REGION_STRIDE = 32'h0000_1000;
    localparam logic [31:0] REGION_SIZE   = 32'h0000_0800;

    // Register indices (byte address bits [5:2])
    localparam logic [3:0] REG_MAC_HI   = 4'd0;
    localparam logic [3:0] REG_MAC_LO   = 4'd1;
    localparam logic [3:0] REG_IP       = 4'd4;
    localparam logic [3:0] REG_SIZES    = 4'd6;
    localparam logic [3:0] REG_PORT     = 4'd8;
    localparam logic [3:0] REG_TX_CNT   = 4'd12;
    localparam logic [3:0] REG_RX_CNT   = 4'd13;
    localparam logic [3:0] REG_STATUS   = 4'd14;
    localparam logic [3:0] REG_IRQ_MASK = 4'd15;

    // STATUS register bit positions
    localparam int unsigned ST_TX_DONE_BIT  = 0;
    localparam int unsigned ST_RX_AVAIL_BIT = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_RD_WAIT,
        S_RMW_RD,
        S_RMW_WR
    } state_t;

    // Replace the bytes of old_val whose enable bit is set (be[i] -> bits [8i+7:8i])
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/opb_mem_rmw.sv
// Memory access helper for the OPB attachment.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        pulse on the cycle a memory access is accepted
//   lat_done     high once the configured read latency has elapsed
//   rd_word      64-bit word returned by the selected region
//   wr_data/be   latched bus write data and byte enables
//   lane         byte address bit 2: 0 = upper half [63:32], 1 = lower half [31:0]
//   rd_half      selected 32-bit half of rd_word
//   merged       rd_word with the enabled bytes of the selected half replaced
module opb_mem_rmw
    import eth_attach_pkg::*;
#(
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        lat_done,
    input  logic [63:0] rd_word,
    input  logic [31:0] wr_data,
    input  logic [3:0]  be,
    input  logic        lane,
    output logic [31:0] rd_half,
    output logic [63:0] merged
);

    logic [1:0] cnt;

    // Loaded with LAT-1 at accept so the wait state lasts exactly MEM_RD_LAT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= 2'(MEM_RD_LAT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 2'd1;
        end
    end

    assign lat_done = (cnt == '0);

    always_comb begin
        rd_half = lane ? rd_word[31:0] : rd_word[63:32];
        if (lane) begin
            merged = {rd_word[63:32], be_merge(rd_word[31:0], wr_data, be)};
        end else begin
            merged = {be_merge(rd_word[63:32], wr_data, be), rd_word[31:0]};
        end
    end

endmodule

// File: rtl/opb_eth_attach_v2.sv
// OPB slave for the 10GbE core: fabric config registers, CPU TX/RX packet
// handshake, packet counters with interrupt, and an N-region 64-bit memory
// window with configurable read latency and byte-merged read-modify-write.
// Ports:
//   OPB_*            OPB slave request side (clock, reset, address, data, BE)
//   Sl_DBus/Sl_xferAck/Sl_toutSup  slave response
//   mem_*            shared memory port: word address, one-hot region, read
//                    data (region r at [64r+63:64r]), merged write data/strobe
//   cpu_tx_*/cpu_rx_* packet handshake with the 10GbE wrapper
//   local_*          fabric MAC/IP/port/enable configuration
//   irq              |(STATUS & IRQ_MASK)
module opb_eth_attach_v2
    import eth_attach_pkg::*;
#(
    parameter logic [31:0]            C_BASEADDR     = 32'h0000_0000,
    parameter logic [31:0]            C_HIGHADDR     = 32'h0000_FFFF,
    parameter int unsigned            NUM_REGIONS    = 3,
    parameter logic [NUM_REGIONS-1:0] REGION_WR_MASK = 3'b101,
    parameter int unsigned            MEM_AWIDTH     = 8,
    parameter int unsigned            MEM_RD_LAT     = 1,
    parameter logic [47:0]            FABRIC_MAC     = '1,
    parameter logic [31:0]            FABRIC_IP      = '1,
    parameter logic [15:0]            FABRIC_PORT    = 16'hFFFF,
    parameter logic                   FABRIC_ENABLE  = 1'b0
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic [3:0]                OPB_BE,
    input  logic [31:0]               OPB_ABus,
    input  logic [31:0]               OPB_DBus,
    output logic [31:0]               Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_toutSup,
    output logic [MEM_AWIDTH-1:0]     mem_addr,
    output logic [NUM_REGIONS-1:0]    mem_region,
    input  logic [64*NUM_REGIONS-1:0] mem_rd_data,
    output logic [63:0]               mem_wr_data,
    output logic                      mem_wr_en,
    output logic [MEM_AWIDTH:0]       cpu_tx_size,
    output logic                      cpu_tx_ready,
    input  logic                      cpu_tx_done,
    input  logic [MEM_AWIDTH:0]       cpu_rx_size,
    output logic                      cpu_rx_ack,
    output logic [47:0]               local_mac,
    output logic [31:0]               local_ip,
    output logic [15:0]               local_port,
    output logic                      local_enable,
    output logic                      irq
);

    // ---------------------------------------------------------------- decode
    logic [31:0]            off;
    logic                   in_win, is_reg, rg_hit, rg_wr_ok, accept, mem_start;
    logic [NUM_REGIONS-1:0] rg_onehot;

    always_comb begin
        off       = OPB_ABus - C_BASEADDR;
        // Offset compare also rejects addresses below the base (they wrap high)
        in_win    = (off <= (C_HIGHADDR - C_BASEADDR));
        is_reg    = (off[31:6] == '0);
        rg_hit    = 1'b0;
        rg_wr_ok  = 1'b0;
        rg_onehot = '0;
        for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
            if (off >= REGION_STRIDE * 32'(r + 1) &&
                off <  REGION_STRIDE * 32'(r + 1) + REGION_SIZE) begin
                rg_hit       = 1'b1;
                rg_onehot[r] = 1'b1;
                rg_wr_ok     = REGION_WR_MASK[r];
            end
        end
    end

    state_t state;
    logic   a_rnw, a_lane, a_mem, a_reg;
    logic [3:0]  a_be, a_idx;
    logic [31:0] a_data;

    assign accept    = (state == S_IDLE) && OPB_select && in_win && !Sl_xferAck;
    // Writes to read-only regions are acked without touching memory
    assign mem_start = accept && rg_hit && (OPB_RNW || rg_wr_ok);

    // ------------------------------------------------------- memory datapath
    logic        lat_done;
    logic [63:0] rd_word;
    logic [31:0] rd_half, reg_rdata, rdata;

    always_comb begin
        rd_word = '0;
        for (int unsigned r = 0; r < NUM_REGIONS; r++) begin
            if (mem_region[r]) rd_word = mem_rd_data[64*r +: 64];
        end
    end

    opb_mem_rmw #(
        .MEM_RD_LAT (MEM_RD_LAT)
    ) u_mem_rmw (
        .clk      (OPB_Clk),
        .rst_n    (OPB_Rst_n),
        .start    (mem_start),
        .lat_done (lat_done),
        .rd_word  (rd_word),
        .wr_data  (a_data),
        .be       (a_be),
        .lane     (a_lane),
        .rd_half  (rd_half),
        .merged   (mem_wr_data)
    );

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state      <= S_IDLE;
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
            Sl_toutSup <= 1'b0;
            mem_addr   <= '0;
            mem_region <= '0;
            mem_wr_en  <= 1'b0;
            a_rnw      <= 1'b0;
            a_lane     <= 1'b0;
            a_mem      <= 1'b0;
            a_reg      <= 1'b0;
            a_be       <= '0;
            a_idx      <= '0;
            a_data     <= '0;
        end else begin
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_rnw    <= OPB_RNW;
                        a_lane   <= OPB_ABus[2];
                        a_be     <= OPB_BE;
                        a_idx    <= OPB_ABus[5:2];
                        a_data   <= OPB_DBus;
                        a_mem    <= mem_start;
                        a_reg    <= is_reg;
                        mem_addr <= OPB_ABus[MEM_AWIDTH+2:3];
                        if (mem_start) begin
                            mem_region <= rg_onehot;
                            Sl_toutSup <= 1'b1;
                            state      <= OPB_RNW ? S_RD_WAIT : S_RMW_RD;
                        end else begin
                            state <= S_ACK;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (lat_done) state <= S_ACK;
                end
                S_RMW_RD: begin
                    if (lat_done) begin
                        mem_wr_en <= 1'b1;
                        state     <= S_RMW_WR;
                    end
                end
                S_RMW_WR: begin
                    mem_wr_en <= 1'b0;
                    state     <= S_ACK;
                end
                S_ACK: begin
                    Sl_xferAck <= 1'b1;
                    Sl_DBus    <= a_rnw ? rdata : '0;
                    mem_region <= '0;
                    Sl_toutSup <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------- registers
    logic [31:0]      tx_cnt, rx_cnt, wr_merged;
    logic [1:0]       irq_mask, status;
    logic             st_tx_done, rx_avail, reg_wr, tx_post, rx_consume;
    logic [MEM_AWIDTH:0] new_tx_size;

    assign rx_avail = (cpu_rx_size != '0) && !cpu_rx_ack;

    always_comb begin
        status                  = '0;
        status[ST_TX_DONE_BIT]  = st_tx_done;
        status[ST_RX_AVAIL_BIT] = rx_avail;
    end

    assign irq = |(status & irq_mask);

    always_comb begin
        case (a_idx)
            REG_MAC_HI:   reg_rdata = {16'h0, local_mac[47:32]};
            REG_MAC_LO:   reg_rdata = local_mac[31:0];
            REG_IP:       reg_rdata = local_ip;
            REG_SIZES:    reg_rdata = {16'(cpu_tx_size),
                                       cpu_rx_ack ? 16'h0 : 16'(cpu_rx_size)};
            REG_PORT:     reg_rdata = {15'h0, local_enable, local_port};
            REG_TX_CNT:   reg_rdata = tx_cnt;
            REG_RX_CNT:   reg_rdata = rx_cnt;
            REG_STATUS:   reg_rdata = {30'h0, status};
            REG_IRQ_MASK: reg_rdata = {30'h0, irq_mask};
            default:      reg_rdata = '0;
        endcase
        rdata = a_mem ? rd_half : (a_reg ? reg_rdata : '0);
    end

    // Byte-enabled writes merge into the register's current readback image
    assign wr_merged   = be_merge(reg_rdata, a_data, a_be);
    assign reg_wr      = (state == S_ACK) && !a_rnw && a_reg;
    assign new_tx_size = a_data[16 +: MEM_AWIDTH+1];
    assign tx_post     = reg_wr && (a_idx == REG_SIZES) && a_be[2] &&
                         (new_tx_size != '0) && !cpu_tx_ready;
    assign rx_consume  = reg_wr && (a_idx == REG_SIZES) && a_be[0] &&
                         (a_data[7:0] == 8'h00) && (cpu_rx_size != '0) && !cpu_rx_ack;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            local_mac    <= FABRIC_MAC;
            local_ip     <= FABRIC_IP;
            local_port   <= FABRIC_PORT;
            local_enable <= FABRIC_ENABLE;
            irq_mask     <= '0;
            tx_cnt       <= '0;
            rx_cnt       <= '0;
            st_tx_done   <= 1'b0;
            cpu_tx_size  <= '0;
            cpu_tx_ready <= 1'b0;
            cpu_rx_ack   <= 1'b0;
        end else begin
            if (reg_wr && a_idx == REG_MAC_HI)   local_mac[47:32] <= wr_merged[15:0];
            if (reg_wr && a_idx == REG_MAC_LO)   local_mac[31:0]  <= wr_merged;
            if (reg_wr && a_idx == REG_IP)       local_ip         <= wr_merged;
            if (reg_wr && a_idx == REG_IRQ_MASK) irq_mask         <= wr_merged[1:0];
            if (reg_wr && a_idx == REG_PORT) begin
                local_port   <= wr_merged[15:0];
                local_enable <= wr_merged[16];
            end

            if (cpu_tx_done) begin
                cpu_tx_size  <= '0;
                cpu_tx_ready <= 1'b0;
            end else if (tx_post) begin
                cpu_tx_size  <= new_tx_size;
                cpu_tx_ready <= 1'b1;
            end

            if (cpu_tx_done) begin
                tx_cnt <= ((reg_wr && a_idx == REG_TX_CNT) ? wr_merged : tx_cnt) + 32'd1;
            end else if (reg_wr && a_idx == REG_TX_CNT) begin
                tx_cnt <= wr_merged;
            end

            if (reg_wr && a_idx == REG_RX_CNT) begin
                rx_cnt <= '0;
            end else if (rx_consume) begin
                rx_cnt <= rx_cnt + 32'd1;
            end

            // Set has priority over write-1-clear
            if (cpu_tx_done) begin
                st_tx_done <= 1'b1;
            end else if (reg_wr && a_idx == REG_STATUS && a_be[0] && a_data[ST_TX_DONE_BIT]) begin
                st_tx_done <= 1'b0;
            end

            if (rx_consume) begin
                cpu_rx_ack <= 1'b1;
            end else if (cpu_rx_ack && cpu_rx_size == '0) begin
                cpu_rx_ack <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_opb_eth_attach_v2.sv
module tb_opb_eth_attach_v2;

    localparam logic [47:0] FMAC = 48'h0A1B_2C3D_4E5F;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         OPB_RNW = 1'b0, OPB_select = 1'b0;
    logic [3:0]   OPB_BE = '0;
    logic [31:0]  OPB_ABus = '0, OPB_DBus = '0;
    logic [31:0]  Sl_DBus;
    logic         Sl_xferAck, Sl_toutSup;
    logic [7:0]   mem_addr;
    logic [2:0]   mem_region;
    logic [191:0] mem_rd_data;
    logic [63:0]  mem_wr_data;
    logic         mem_wr_en;
    logic [8:0]   cpu_tx_size;
    logic         cpu_tx_ready;
    logic         cpu_tx_done = 1'b0;
    logic [8:0]   cpu_rx_size = '0;
    logic         cpu_rx_ack;
    logic [47:0]  local_mac;
    logic [31:0]  local_ip;
    logic [15:0]  local_port;
    logic         local_enable, irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    opb_eth_attach_v2 #(
        .MEM_RD_LAT (3),
        .FABRIC_MAC (FMAC)
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .OPB_RNW      (OPB_RNW),
        .OPB_select   (OPB_select),
        .OPB_BE       (OPB_BE),
        .OPB_ABus     (OPB_ABus),
        .OPB_DBus     (OPB_DBus),
        .Sl_DBus      (Sl_DBus),
        .Sl_xferAck   (Sl_xferAck),
        .Sl_toutSup   (Sl_toutSup),
        .mem_addr     (mem_addr),
        .mem_region   (mem_region),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .cpu_tx_size  (cpu_tx_size),
        .cpu_tx_ready (cpu_tx_ready),
        .cpu_tx_done  (cpu_tx_done),
        .cpu_rx_size  (cpu_rx_size),
        .cpu_rx_ack   (cpu_rx_ack),
        .local_mac    (local_mac),
        .local_ip     (local_ip),
        .local_port   (local_port),
        .local_enable (local_enable),
        .irq          (irq)
    );

    // Memory model: 3 regions x 256 words, 3-cycle read pipeline
    logic [63:0]  mem [3][256];
    logic [191:0] pipe [3];
    logic         pl_en = 1'b0;
    int           pl_rg = 0;
    logic [7:0]   pl_addr = '0;
    logic [63:0]  pl_data = '0;

    assign mem_rd_data = pipe[2];

    always @(posedge clk) begin
        pipe[0] <= {mem[2][mem_addr], mem[1][mem_addr], mem[0][mem_addr]};
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
        if (pl_en) begin
            mem[pl_rg][pl_addr] <= pl_data;
        end else if (mem_wr_en) begin
            for (int r = 0; r < 3; r++)
                if (mem_region[r]) mem[r][mem_addr] <= mem_wr_data;
        end
    end

    task automatic preload(input int rg, input logic [7:0] a, input logic [63:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_rg = rg; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One bus transfer; ack_cyc counts cycles after the accept edge (-1 = no ack)
    task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int ack_cyc, output int wr_cnt,
                        output logic [63:0] wr_data, output logic [7:0] tout);
        @(negedge clk);
        OPB_select = 1'b1; OPB_RNW = rnw; OPB_ABus = addr; OPB_BE = be; OPB_DBus = wdata;
        @(posedge clk);
        ack_cyc = -1; wr_cnt = 0; wr_data = '0; tout = '0; rdata = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 8) tout[c] = Sl_toutSup;
            if (mem_wr_en) begin wr_cnt++; wr_data = mem_wr_data; end
            if (Sl_xferAck) begin ack_cyc = c; rdata = Sl_DBus; break; end
        end
        OPB_select = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk); cpu_tx_done = 1'b1;
        @(negedge clk); cpu_tx_done = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (Sl_xferAck !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", Sl_xferAck); end
        checks++; if (Sl_DBus !== 32'h0) begin failures++; $display("FAIL rst_dbus got=%h exp=0", Sl_DBus); end
        checks++; if ({Sl_toutSup, mem_wr_en, mem_region} !== 5'b0) begin failures++; $display("FAIL rst_mem got=%b exp=0", {Sl_toutSup, mem_wr_en, mem_region}); end
        checks++; if ({cpu_tx_ready, cpu_tx_size, cpu_rx_ack, irq} !== 12'h0) begin failures++; $display("FAIL rst_cpu got=%h exp=0", {cpu_tx_ready, cpu_tx_size, cpu_rx_ack, irq}); end
        checks++; if (local_mac !== FMAC) begin failures++; $display("FAIL rst_mac got=%h exp=%h", local_mac, FMAC); end
        checks++; if ({local_ip, local_port, local_enable} !== {32'hFFFFFFFF, 16'hFFFF, 1'b0}) begin failures++; $display("FAIL rst_ip_port got=%h exp=%h", {local_ip, local_port, local_enable}, {32'hFFFFFFFF, 16'hFFFF, 1'b0}); end
        rst_n = 1'b1;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        OPB_select = 1'b1; OPB_RNW = 1'b0; OPB_ABus = 32'h1000; OPB_BE = 4'hF; OPB_DBus = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; OPB_select = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if ({Sl_xferAck, mem_wr_en, Sl_toutSup} !== 3'b0) begin failures++; $display("FAIL abort_c%0d got=%b exp=000", c, {Sl_xferAck, mem_wr_en, Sl_toutSup}); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_regs();
        logic [31:0] rd; int ac, wc; logic [63:0] wd; logic [7:0] tb;
        xfer(1'b1, 32'h04, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (rd !== 32'h2C3D4E5F) begin failures++; $display("FAIL rd_mac_lo got=%h exp=2c3d4e5f", rd); end
        checks++; if (ac !== 1) begin failures++; $display("FAIL reg_ack_cyc got=%0d exp=1", ac); end
        xfer(1'b1, 32'h00, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (rd !== 32'h00000A1B) begin failures++; $display("FAIL rd_mac_hi got=%h exp=00000a1b", rd); end
        xfer(1'b0, 32'h10, 4'b0011, 32'h0A0B0C0D, rd, ac, wc, wd, tb);
        checks++; if (local_ip !== 32'hFFFF0C0D) begin failures++; $display("FAIL ip_be got=%h exp=ffff0c0d", local_ip); end
        xfer(1'b0, 32'h20, 4'hF, 32'h0001_1234, rd, ac, wc, wd, tb);
        checks++; if ({local_enable, local_port} !== 17'h11234) begin failures++; $display("FAIL port_en got=%h exp=11234", {local_enable, local_port}); end
        xfer(1'b1, 32'h08, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if ({ac, rd} !== {32'd1, 32'h0}) begin failures++; $display("FAIL unmapped_rd got=%0d/%h exp=1/0", ac, rd); end
        xfer(1'b1, 32'hFFFC, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if ({ac, rd} !== {32'd1, 32'h0}) begin failures++; $display("FAIL top_of_window got=%0d/%h exp=1/0", ac, rd); end
        xfer(1'b1, 32'h0001_0000, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (ac !== -1) begin failures++; $display("FAIL out_of_window_ack got=%0d exp=-1", ac); end
    endtask

    task automatic test_rmw();
        logic [31:0] rd; int ac, wc; logic [63:0] wd; logic [7:0] tb;
        preload(0, 8'd0, 64'h1111_1111_1111_1111);
        xfer(1'b0, 32'h1004, 4'b0001, 32'h0000_00AA, rd, ac, wc, wd, tb);
        checks++; if (wc !== 1) begin failures++; $display("FAIL rmw_wr_count got=%0d exp=1", wc); end
        checks++; if (wd !== 64'h1111_1111_1111_11AA) begin failures++; $display("FAIL rmw_wr_data got=%h exp=11111111111111aa", wd); end
        checks++; if (ac !== 5) begin failures++; $display("FAIL rmw_ack_cyc got=%0d exp=5", ac); end
        checks++; if (tb !== 8'h1F) begin failures++; $display("FAIL rmw_toutsup got=%b exp=00011111", tb); end
        xfer(1'b1, 32'h1004, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if ({ac, rd} !== {32'd4, 32'h111111AA}) begin failures++; $display("FAIL rmw_readback got=%0d/%h exp=4/111111aa", ac, rd); end
        preload(2, 8'd1, 64'h0);
        xfer(1'b0, 32'h3008, 4'b1100, 32'hDEAD_BEEF, rd, ac, wc, wd, tb);
        checks++; if ({wc, wd} !== {32'd1, 64'hDEAD0000_00000000}) begin failures++; $display("FAIL upper_lane_wr got=%0d/%h exp=1/dead000000000000", wc, wd); end
    endtask

    task automatic test_ro_region();
        logic [31:0] rd; int ac, wc; logic [63:0] wd; logic [7:0] tb;
        preload(1, 8'd0, 64'h12345678_9ABCDEF0);
        xfer(1'b0, 32'h2000, 4'hF, 32'hFFFF_FFFF, rd, ac, wc, wd, tb);
        checks++; if ({ac, wc} !== {32'd1, 32'd0}) begin failures++; $display("FAIL ro_write got=%0d/%0d exp=1/0", ac, wc); end
        xfer(1'b1, 32'h2000, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if ({ac, rd} !== {32'd4, 32'h12345678}) begin failures++; $display("FAIL ro_read_hi got=%0d/%h exp=4/12345678", ac, rd); end
        xfer(1'b1, 32'h2004, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (rd !== 32'h9ABCDEF0) begin failures++; $display("FAIL ro_read_lo got=%h exp=9abcdef0", rd); end
    endtask

    task automatic test_tx();
        logic [31:0] rd; int ac, wc; logic [63:0] wd; logic [7:0] tb;
        xfer(1'b0, 32'h3C, 4'b0001, 32'h1, rd, ac, wc, wd, tb);
        xfer(1'b0, 32'h18, 4'b0100, 32'h0014_0000, rd, ac, wc, wd, tb);
        checks++; if ({cpu_tx_ready, cpu_tx_size} !== {1'b1, 9'd20}) begin failures++; $display("FAIL tx_post got=%b/%0d exp=1/20", cpu_tx_ready, cpu_tx_size); end
        xfer(1'b1, 32'h18, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (rd !== 32'h0014_0000) begin failures++; $display("FAIL sizes_rd got=%h exp=00140000", rd); end
        xfer(1'b0, 32'h18, 4'b0100, 32'h001E_0000, rd, ac, wc, wd, tb);
        checks++; if (cpu_tx_size !== 9'd20) begin failures++; $display("FAIL tx_repost got=%0d exp=20", cpu_tx_size); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_before_done got=%b exp=0", irq); end
        pulse_done();
        checks++; if ({cpu_tx_ready, cpu_tx_size, irq} !== {1'b0, 9'd0, 1'b1}) begin failures++; $display("FAIL tx_done got=%b/%0d/%b exp=0/0/1", cpu_tx_ready, cpu_tx_size, irq); end
        xfer(1'b1, 32'h30, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL tx_cnt got=%h exp=1", rd); end
        xfer(1'b0, 32'h38, 4'b0001, 32'h1, rd, ac, wc, wd, tb);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL status_w1c_irq got=%b exp=0", irq); end
    endtask

    task automatic test_rx();
        logic [31:0] rd; int ac, wc; logic [63:0] wd; logic [7:0] tb;
        @(negedge clk); cpu_rx_size = 9'd16;
        xfer(1'b1, 32'h38, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (rd !== 32'h2) begin failures++; $display("FAIL rx_avail got=%h exp=2", rd); end
        xfer(1'b0, 32'h18, 4'b0001, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (cpu_rx_ack !== 1'b1) begin failures++; $display("FAIL rx_ack_set got=%b exp=1", cpu_rx_ack); end
        xfer(1'b1, 32'h18, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rx_size_hidden got=%h exp=0", rd); end
        xfer(1'b1, 32'h34, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL rx_cnt got=%h exp=1", rd); end
        @(negedge clk); cpu_rx_size = 9'd0;
        @(negedge clk);
        checks++; if (cpu_rx_ack !== 1'b0) begin failures++; $display("FAIL rx_ack_drop got=%b exp=0", cpu_rx_ack); end
        xfer(1'b0, 32'h34, 4'b0001, 32'h0, rd, ac, wc, wd, tb);
        xfer(1'b1, 32'h34, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rx_cnt_clear got=%h exp=0", rd); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; int ac, wc; logic [63:0] wd; logic [7:0] tb;
        xfer(1'b0, 32'h30, 4'hF, 32'hFFFF_FFFF, rd, ac, wc, wd, tb);
        xfer(1'b1, 32'h30, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL tx_cnt_preset got=%h exp=ffffffff", rd); end
        pulse_done();
        xfer(1'b1, 32'h30, 4'hF, 32'h0, rd, ac, wc, wd, tb);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL tx_cnt_wrap got=%h exp=0", rd); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_after_wrap got=%b exp=1", irq); end
    endtask

    initial begin
        test_reset();
        test_reset_abort();
        test_regs();
        test_rmw();
        test_ro_region();
        test_tx();
        test_rx();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opb_eth_attach_v2.md
Name: opb_eth_attach_v2

Overview:
- Parametrised OPB slave for the 10GbE core: network config registers, TX/RX CPU packet handshake, irq/packet counters, and a generic N-region 64-bit memory window with configurable read latency and byte-merged read-modify-write.
- Sits between the OPB bus and the 10GbE wrapper; Sl_errAck/Sl_retry are tied 0 by the pcore wrapper.

Parameters:
- C_BASEADDR, 32'h0, base of decoded window
- C_HIGHADDR, 32'hFFFF, top of decoded window
- NUM_REGIONS, 3, memory regions (1..7); region r at offset 0x1000*(r+1), 0x800 bytes; r0=TX buf, r1=RX buf, r2=ARP cache
- REGION_WR_MASK, 3'b101, bit r set = region r writable
- MEM_AWIDTH, 8, 64-bit word address width per region (<=8); MEM_RD_LAT, 1, memory read latency 1..3; FABRIC_MAC/IP/PORT/ENABLE, all-ones/all-ones/16'hFFFF/0, register reset values

Ports:
- OPB_Clk  in  1  bus clock
- OPB_Rst_n  in  1  reset, asynchronous, active-low
- OPB_RNW  in  1  1=read
- OPB_select  in  1  transfer request
- OPB_BE  in  4  byte enables
- OPB_ABus  in  32  address
- OPB_DBus  in  32  write data
- Sl_DBus  out  32  read data, 0 unless Sl_xferAck
- Sl_xferAck  out  1  one-cycle ack
- Sl_toutSup  out  1  high while a memory access is in progress
- mem_addr  out  MEM_AWIDTH  word address (byte addr[MEM_AWIDTH+2:3])
- mem_region  out  NUM_REGIONS  one-hot region select, held for the whole access
- mem_rd_data  in  64*NUM_REGIONS  packed read data, region r at [64r+63:64r]
- mem_wr_data  out  64  merged write data
- mem_wr_en  out  1  one-cycle write strobe
- cpu_tx_size  out  MEM_AWIDTH+1  TX packet length in words
- cpu_tx_ready  out  1  TX packet posted
- cpu_tx_done  in  1  pulse: wrapper sent packet
- cpu_rx_size  in  MEM_AWIDTH+1  RX packet length, 0 = none
- cpu_rx_ack  out  1  CPU has consumed RX packet
- local_mac  out  48  fabric MAC
- local_ip  out  32  fabric IP
- local_port  out  16  fabric UDP port
- local_enable  out  1  fabric enable
- irq  out  1  |(status & mask)

Behaviour:
- Reset: outputs 0 except local_* = FABRIC_*; FSM IDLE; counters, status, mask 0. Reset mid-access aborts: no ack, mem_wr_en low.
- Accept only in IDLE with OPB_select, address in [C_BASEADDR,C_HIGHADDR], Sl_xferAck low; latch address/BE/data/RNW at accept (cycle 0).
- FSM IDLE->ACK (register or unmapped in-window address; ack cycle 1, unmapped reads 0, writes dropped); IDLE->RD_WAIT (MEM_RD_LAT cycles)->ACK, ack cycle MEM_RD_LAT+1; IDLE->RMW_RD (MEM_RD_LAT)->RMW_WR (mem_wr_en=1)->ACK, ack cycle MEM_RD_LAT+2. Writes to read-only region: IDLE->ACK, no strobe.
- Word lane: byte addr[2]=0 selects [63:32], 1 selects [31:0]; RMW replaces only enabled bytes of the selected half.
- Registers (index = addr[5:2]): 0 MAC[47:32]; 1 MAC[31:0]; 4 IP; 6 sizes {tx_size@[31:16], rx_size@[15:0]}; 8 {enable@16, port@[15:0]}; 12 TX_PKT_CNT; 13 RX_PKT_CNT (any write clears); 14 STATUS {rx_avail@1, tx_done@0}, write-1-clear; 15 IRQ_MASK[1:0]. Byte-enabled writes.
- TX: write to reg 6 with BE[2] and nonzero size while cpu_tx_ready=0 -> size latched, ready=1. Write while ready=1 ignored, including the cpu_tx_done cycle. cpu_tx_done: size<=0, ready<=0, TX_PKT_CNT+1, STATUS.tx_done<=1.
- RX: STATUS.rx_avail = (cpu_rx_size!=0 && !cpu_rx_ack). Writing 0 to reg-6 byte 0 with cpu_rx_size!=0 sets cpu_rx_ack, increments RX_PKT_CNT; ack held until cpu_rx_size==0; reads return rx_size 0 while ack high.
- Counters 32-bit, wrap FFFFFFFF->0. Write-1-clear coinciding with a set: set wins.

Decomposition:
- Shared package eth_attach_pkg: region offsets/size, register indices, STATUS bit positions, FSM state enum.
- One sub-module opb_mem_rmw: lane merge and latency counter FSM for memory accesses.

Test Plan:
- Reset, read reg 1 -> FABRIC_MAC[31:0], ack cycle 1; write reg 4 BE=4'b0011 data 32'h0A0B0C0D with reset IP FFFFFFFF -> IP FFFF0C0D.
- MEM_RD_LAT=3, write region 0 addr 0x1004 BE=4'b0001 data 0xAA, old word 0x1111..11 -> mem_wr_en once with 0x11111111111111AA, ack cycle 5, Sl_toutSup high cycles 0-4.
- Write region 1 (read-only) -> ack cycle 1, no mem_wr_en; read 0x2000 with word 0x12345678_9ABCDEF0 -> 0x12345678.
- Post tx_size 20, second post 30 ignored; cpu_tx_done -> size 0, ready 0, TX_PKT_CNT 1, irq when mask=1.
- cpu_rx_size=16, write 0 to reg 6 byte 0 -> cpu_rx_ack=1, reads show rx 0; cpu_rx_size->0 -> ack drops; TX_PKT_CNT preset FFFFFFFF + done -> 0.
